// File: rtl/gcd_operand_sequencer.sv
// Operand FIFO and issue FSM feeding a gcd core; zero operands are resolved locally.
// Optional completion watchdog is compiled in when GCD_SEQ_TIMEOUT_EN is defined.
module gcd_operand_sequencer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic [WIDTH-1:0]       gcd_a,
    output logic [WIDTH-1:0]       gcd_b,
    output logic                   gcd_load_n,
    input  logic                   gcd_done,
    input  logic [WIDTH-1:0]       gcd_y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_y,
    output logic                   out_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("gcd_operand_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic             tmo_hit;

    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = (state == S_IDLE) && (count != '0);
    assign head_a   = mem_a[rd_ptr];
    assign head_b   = mem_b[rd_ptr];
    assign busy     = (state != S_IDLE) || (count != '0);

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        gcd_load_n = 1'b1;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop) state_nxt = (head_a == '0 || head_b == '0) ? S_OUT : S_LOAD;
            end
            S_LOAD: begin
                gcd_load_n = 1'b0;
                state_nxt  = S_SETTLE;
            end
            // done may still be high from the previous result; it is ignored here
            S_SETTLE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (gcd_done || tmo_hit) state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gcd_a <= '0;
            gcd_b <= '0;
            out_y <= '0;
        end else if (pop) begin
            gcd_a <= head_a;
            gcd_b <= head_b;
            if (head_a == '0)      out_y <= head_b;
            else if (head_b == '0) out_y <= head_a;
        end else if (state == S_WAIT) begin
            if (gcd_done)     out_y <= gcd_y;
            else if (tmo_hit) out_y <= '0;
        end
    end

`ifdef GCD_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == S_WAIT) && !gcd_done && (tmo_cnt >= TW'(TIMEOUT));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            out_err <= 1'b0;
        end else begin
            if (state == S_LOAD)
                tmo_cnt <= '0;
            else if ((state == S_SETTLE || state == S_WAIT) && !tmo_hit)
                tmo_cnt <= tmo_cnt + TW'(1);
            if (pop)
                out_err <= 1'b0;
            else if (state == S_WAIT && gcd_done)
                out_err <= 1'b0;
            else if (tmo_hit)
                out_err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Bench for gcd_operand_sequencer: behavioural gcd core, result scoreboard, directed and random traffic.
module tb_gcd_operand_sequencer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] gcd_a;
    logic [WIDTH-1:0] gcd_b;
    logic             gcd_load_n;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_err;
    logic             busy;
    logic [2:0]       count;

    gcd_operand_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(20)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_load_n(gcd_load_n),
        .gcd_done(gcd_done), .gcd_y(gcd_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_err(out_err),
        .busy(busy), .count(count)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {logic [7:0] y; logic err;} exp_t;
    typedef struct {logic [7:0] a; logic [7:0] b;} pair_t;

    exp_t       sb_q[$];
    pair_t      load_q[$];
    logic [7:0] got_q[$];
    bit         core_hang = 1'b0;
    int         fixed_lat = 0;

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x[7:0];
    endfunction

    // Core model: latches operands on load, drops the stale done one cycle late, then answers.
    logic [7:0] la, lb;
    int         phase, lat_cnt;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            gcd_done <= 1'b0;
            gcd_y    <= '0;
            phase    <= 0;
            lat_cnt  <= 0;
        end else if (!gcd_load_n) begin
            la    <= gcd_a;
            lb    <= gcd_b;
            phase <= 1;
        end else if (phase == 1) begin
            gcd_done <= 1'b0;
            gcd_y    <= ref_gcd(la, lb);
            lat_cnt  <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
            phase    <= 2;
        end else if (phase == 2 && !core_hang) begin
            if (lat_cnt <= 1) begin
                gcd_done <= 1'b1;
                phase    <= 0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // Compare process: every mid-cycle sample while out of reset.
    logic       prev_ov, prev_or, prev_load_low, prev_err;
    logic [7:0] prev_y;
    exp_t       me;
    pair_t      mp;
    always @(negedge clock) begin
        if (!reset) begin
            prev_ov       = 1'b0;
            prev_or       = 1'b0;
            prev_load_low = 1'b0;
        end else begin
            if (prev_ov && !prev_or) begin
                n_cmp++;
                if (!(out_valid && out_y == prev_y && out_err == prev_err)) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid/y/err=%0b/%0d/%0b required 1/%0d/%0b",
                             out_valid, out_y, out_err, prev_y, prev_err);
                end
            end
            n_cmp++;
            if (in_ready !== (count != DEPTH)) begin
                n_fail++;
                $display("FAIL in_ready: got %0b with count %0d", in_ready, count);
            end
            if (!gcd_load_n) begin
                n_cmp++;
                if (prev_load_low || load_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL load_pulse: unexpected low (prev_low=%0b pending=%0d)",
                             prev_load_low, load_q.size());
                end else begin
                    mp = load_q.pop_front();
                    if (gcd_a != mp.a || gcd_b != mp.b) begin
                        n_fail++;
                        $display("FAIL load_operands: got %0d,%0d required %0d,%0d",
                                 gcd_a, gcd_b, mp.a, mp.b);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                got_q.push_back(out_y);
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL result_unexpected: got y=%0d err=%0b, required none", out_y, out_err);
                end else begin
                    me = sb_q.pop_front();
                    if (out_y != me.y || out_err != me.err) begin
                        n_fail++;
                        $display("FAIL result: got y=%0d err=%0b, required y=%0d err=%0b",
                                 out_y, out_err, me.y, me.err);
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (core_hang && in_a != 0 && in_b != 0) begin
                    me.y   = 8'd0;
                    me.err = 1'b1;
                end else begin
                    me.y   = ref_gcd(in_a, in_b);
                    me.err = 1'b0;
                end
                sb_q.push_back(me);
                if (in_a != 0 && in_b != 0) begin
                    mp.a = in_a;
                    mp.b = in_b;
                    load_q.push_back(mp);
                end
            end
            prev_ov       = out_valid;
            prev_or       = out_ready;
            prev_load_low = !gcd_load_n;
            prev_y        = out_y;
            prev_err      = out_err;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic push(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        expire("push_accept");
    endtask

    task automatic wait_ov(input string name);
        for (int i = 0; i < 300; i++) begin
            if (out_valid) return;
            @(negedge clock);
        end
        expire(name);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (!busy && sb_q.size() == 0) begin
                @(posedge clock);
                #1;
                return;
            end
            @(negedge clock);
        end
        expire(name);
        @(posedge clock);
        #1;
    endtask

    task automatic accept_one();
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_gcd_a"}, gcd_a, 0);
        check({tag, "_gcd_b"}, gcd_b, 0);
        check({tag, "_load_n"}, gcd_load_n, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_y"}, out_y, 0);
        check({tag, "_out_err"}, out_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_count"}, count, 0);
    endtask

    function automatic logic [7:0] rand_op();
        if ($urandom % 8 == 0) return 8'd0;
        return 8'($urandom_range(1, 15) * $urandom_range(1, 16));
    endfunction

    logic [7:0] exp_full [5];

    initial begin
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #12;
        check_reset_values("rst");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Basic core path with load timing
        fixed_lat = 6;
        push(8'd50, 8'd20);
        @(negedge clock);
        check("basic_load_n_n1", gcd_load_n, 1);
        @(negedge clock);
        check("basic_load_n_n2", gcd_load_n, 0);
        check("basic_gcd_a", gcd_a, 50);
        check("basic_gcd_b", gcd_b, 20);
        @(negedge clock);
        check("basic_load_n_n3", gcd_load_n, 1);
        wait_ov("basic_out_valid");
        check("basic_out_y", out_y, 10);
        check("basic_out_err", out_err, 0);
        accept_one();

        // Stale done left high from the previous result
        out_ready = 1'b1;
        push(8'd30, 8'd45);
        wait_ov("stale_out_valid");
        check("stale_out_y", out_y, 15);
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        wait_idle("stale_idle");

        // Zero bypass with latency
        for (int k = 0; k < 3; k++) begin
            logic [7:0] a, b, y;
            a = (k == 1) ? 8'd42 : 8'd0;
            b = (k == 0) ? 8'd35 : 8'd0;
            y = (k == 0) ? 8'd35 : (k == 1) ? 8'd42 : 8'd0;
            push(a, b);
            @(negedge clock);
            check("bypass_valid_n1", out_valid, 0);
            @(negedge clock);
            check("bypass_valid_n2", out_valid, 1);
            check("bypass_out_y", out_y, y);
            accept_one();
        end
        wait_idle("bypass_idle");

        // FIFO full, refusal, ordered drain
        fixed_lat = 0;
        exp_full  = '{8'd6, 8'd1, 8'd9, 8'd25, 8'd16};
        push(8'd12, 8'd18);
        push(8'd7, 8'd13);
        push(8'd9, 8'd9);
        push(8'd100, 8'd75);
        push(8'd64, 8'd48);
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_a     = 8'd1;
        in_b     = 8'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("full_refuse_ready", in_ready, 0);
            check("full_refuse_count", count, 4);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 400 && got_q.size() < 5; i++) @(negedge clock);
        if (got_q.size() < 5) expire("full_drain");
        else for (int i = 0; i < 5; i++) check("full_order", got_q[i], exp_full[i]);
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        wait_idle("full_idle");

        // Reset while waiting on the core with entries queued
        fixed_lat = 30;
        push(8'd3, 8'd6);
        push(8'd10, 8'd4);
        push(8'd14, 8'd21);
        push(8'd5, 8'd15);
        check("rstmid_count", count, 3);
        check("rstmid_busy", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("rstmid");
        sb_q.delete();
        load_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset     = 1'b1;
        fixed_lat = 0;
        out_ready = 1'b1;
        repeat (30) @(negedge clock);
        check("rstmid_no_result", out_valid, 0);
        check("rstmid_idle", busy, 0);
        @(posedge clock);
        #1;

`ifdef GCD_SEQ_TIMEOUT_EN
        // Watchdog abort, then a normal pair
        core_hang = 1'b1;
        push(8'd9, 8'd6);
        wait_ov("tmo_out_valid");
        check("tmo_out_y", out_y, 0);
        check("tmo_out_err", out_err, 1);
        @(posedge clock);
        #1;
        core_hang = 1'b0;
        wait_idle("tmo_idle");
        push(8'd8, 8'd12);
        wait_ov("tmo_next_valid");
        check("tmo_next_y", out_y, 4);
        check("tmo_next_err", out_err, 0);
        @(posedge clock);
        #1;
        wait_idle("tmo_next_idle");
`endif

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom % 3) != 0;
            in_a      = rand_op();
            in_b      = rand_op();
            out_ready = ($urandom % 4) != 0;
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle("random_drain");
        check("random_sb_empty", sb_q.size(), 0);
        check("random_load_q_empty", load_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_operand_sequencer.md
# gcd_operand_sequencer

Upstream feeder for the `gcd_rtl` core. It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It issues each pair to the core with a one-cycle `load_n` pulse, waits for `done`, and returns the result over a valid/ready output stream. Zero operands are resolved locally, so the core never sees a zero input.

## Interface
- `WIDTH`, 8, operand/result width; must match the core's `width`
- `DEPTH`, 4, input FIFO entries; power of 2, ≥ 2
- `TIMEOUT`, 255, watchdog limit in cycles; only used with `GCD_SEQ_TIMEOUT_EN`

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `in_valid`  in  1  operand pair offered
- `in_ready`  out  1  FIFO can accept; equals not-full
- `in_a`, `in_b`  in  WIDTH  operands
- `gcd_a`, `gcd_b`  out  WIDTH  operands to the core
- `gcd_load_n`  out  1  active-low load strobe to the core
- `gcd_done`  in  1  core result valid
- `gcd_y`  in  WIDTH  core result
- `out_valid`  out  1  result held
- `out_ready`  in  1  downstream accepts
- `out_y`  out  WIDTH  GCD result
- `out_err`  out  1  result aborted by the watchdog
- `busy`  out  1  FSM not in IDLE, or FIFO not empty
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- **FIFO.** Push on `in_valid & in_ready`. The FSM pops in IDLE only.
  - A push at full is refused even if a pop occurs in the same cycle.
  - A simultaneous push and pop leaves `count` unchanged.
  - Read and write pointers wrap modulo `DEPTH`.
- **FSM states:** IDLE, LOAD, SETTLE, WAIT, OUT.
- **IDLE**, FIFO not empty:
  - Pop the head entry into the `gcd_a`/`gcd_b` registers.
  - If `a == 0`: set `out_y = b` and go to OUT (bypass).
  - Else if `b == 0`: set `out_y = a` and go to OUT (bypass).
  - Otherwise go to LOAD.
  - For the pair 0,0 the result is 0, via bypass.
- **LOAD:** `gcd_load_n = 0` for exactly one cycle, then go to SETTLE.
- **SETTLE:** one cycle. `gcd_done` is ignored, to mask a stale `done` left over from the previous result. Then go to WAIT.
- **WAIT:** on `gcd_done == 1`, capture `gcd_y` into `out_y`, clear `out_err`, and go to OUT.
- **OUT:** `out_valid = 1`. On `out_ready`, go to IDLE.
  - `out_y` and `out_err` hold stable while `out_valid & !out_ready`.
- `gcd_a` and `gcd_b` hold stable from LOAD until the next pop.
- Operands are unsigned. `out_y` is exactly `WIDTH` bits, and no arithmetic beyond the zero compares is performed.

## Timing
- **Reset values:**
  - `in_ready` = 1
  - `gcd_a`, `gcd_b` = 0
  - `gcd_load_n` = 1
  - `out_valid` = 0
  - `out_y` = 0
  - `out_err` = 0
  - `busy` = 0
  - `count` = 0
  - FSM in IDLE
- **Core path latency:** push in cycle N → pop in N+1 → LOAD in N+2 → SETTLE in N+3 → WAIT from N+4. `out_valid` rises in the cycle after `gcd_done` is first sampled in WAIT.
- **Bypass latency:** push in cycle N → `out_valid` high in N+2.
- **Back-to-back results:** if `out_ready` is held high, IDLE follows OUT, so the minimum spacing is 2 cycles (bypass) or 5 cycles plus core compute time.
- **`in_ready`:** combinational from `count`; it does not depend on `in_valid`.
- **`out_valid`:** once raised, it never drops without handshake acceptance.
- **Reset mid-operation:** the FIFO is discarded, any in-flight result is lost, and `gcd_load_n` returns to 1 immediately.

## Configuration
- **Macro:** `GCD_SEQ_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to LOAD and increments in SETTLE and WAIT.
  - If it reaches `TIMEOUT` without `gcd_done`, go to OUT with `out_y = 0` and `out_err = 1`.
  - The next pair proceeds normally.
- **Undefined:** WAIT waits indefinitely, `out_err` is tied to 0, and no counter logic is present.

## Test plan
- **Basic GCD.** Push (50, 20); the core model returns 10 after 6 cycles. Expect one `gcd_load_n` low pulse with `gcd_a = 50`, `gcd_b = 20`, then `out_y = 10`, `out_valid = 1`, `out_err = 0`.
- **FIFO full.** Hold `out_ready = 0` and push 5 pairs.
  - Expect `count` to reach 4; the first pair is popped into the FSM, which then stalls in OUT.
  - Expect `in_ready = 0` after the 5th push, with the 6th refused.
  - Release `out_ready` and expect 5 results in order: (12,18) → 6, (7,13) → 1, (9,9) → 9, (100,75) → 25, (64,48) → 16.
- **Zero bypass.** Push (0, 35), (42, 0), (0, 0). Expect `out_y` = 35, 42, 0; no `gcd_load_n` pulse; each `out_valid` 2 cycles after its push.
- **Stale done.** Leave `gcd_done` stuck at 1 from the prior result and push (30, 45). Expect the SETTLE mask, then capture of `gcd_y = 15` only in WAIT.
- **Reset mid-WAIT.** Assert `reset` low asynchronously with 3 entries queued. Expect all outputs at reset values immediately, and no result after release.
- **Timeout** (`GCD_SEQ_TIMEOUT_EN`, `TIMEOUT = 20`). Never assert `gcd_done`. Expect `out_valid` with `out_y = 0`, `out_err = 1`; the next pair (8, 12) then yields 4 with `out_err = 0`.
